// File: rtl/perf_counter_pkg.sv
// perf_counter_pkg: shared config type and mode encodings for the perf counter bank
package perf_counter_pkg;
  localparam int EVT_SEL_MAX_W = 8;
  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE = 1'b1;
  localparam logic OVF_WRAP = 1'b0;
  localparam logic OVF_SAT = 1'b1;
  typedef struct packed {
    logic [EVT_SEL_MAX_W-1:0] evt_sel;
    logic edge_mode;
    logic sat;
    logic en;
  } cnt_cfg_t;
  localparam cnt_cfg_t CFG_RESET = '{evt_sel: '0, edge_mode: MODE_LEVEL, sat: OVF_WRAP, en: 1'b0};
endpackage

// File: rtl/perf_counter_slice.sv
// perf_counter_slice: one programmable event counter with overflow flag and shadow
module perf_counter_slice
  import perf_counter_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int NUM_EVENTS = 16,
  parameter int EVT_SEL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [NUM_EVENTS-1:0] prev_i,
  input  logic                  global_en_i,
  input  logic                  cfg_we_i,
  input  logic [EVT_SEL_W-1:0]  cfg_evt_sel_i,
  input  logic                  cfg_edge_i,
  input  logic                  cfg_sat_i,
  input  logic                  cfg_en_i,
  input  logic                  clr_i,
  input  logic                  ovf_clr_i,
  input  logic                  snap_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic [CNT_WIDTH-1:0]  shadow_o,
  output logic                  ovf_o
);
  cnt_cfg_t cfg_q, cfg_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, shadow_q, shadow_d;
  logic ovf_q, ovf_d;
  logic [EVT_SEL_W-1:0] sel;
  logic hit, at_max;
  always_comb begin
    sel = cfg_q.evt_sel[EVT_SEL_W-1:0];
    // edge mode compares against last cycle's sample, so a line already high never counts
    hit = global_en_i & cfg_q.en & (32'(cfg_q.evt_sel) < NUM_EVENTS) & event_i[sel]
        & ((cfg_q.edge_mode != MODE_EDGE) | ~prev_i[sel]);
    at_max = &cnt_q;
    cnt_d = clr_i ? '0 : !hit ? cnt_q : !at_max ? cnt_q + CNT_WIDTH'(1) : cfg_q.sat == OVF_SAT ? cnt_q : '0;
    ovf_d = (hit & at_max & ~clr_i) | (ovf_q & ~ovf_clr_i);
    shadow_d = snap_i ? cnt_q : shadow_q;
    cfg_d = cfg_we_i ? cnt_cfg_t'{evt_sel: EVT_SEL_MAX_W'(cfg_evt_sel_i), edge_mode: cfg_edge_i,
                                  sat: cfg_sat_i, en: cfg_en_i} : cfg_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q <= CFG_RESET;
      cnt_q <= '0;
      shadow_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
      ovf_q <= ovf_d;
    end
  end
  assign count_o = cnt_q;
  assign shadow_o = shadow_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: bank of run-time routable event counters with snapshot, read port and overflow irq
module perf_counter_bank
  import perf_counter_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int NUM_COUNTERS = 8,
  parameter int NUM_EVENTS = 16,
  parameter int EVT_SEL_W = $clog2(NUM_EVENTS),
  parameter int IDX_W = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_EVENTS-1:0]   event_in,
  input  logic                    global_en,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_idx,
  input  logic [EVT_SEL_W-1:0]    cfg_evt_sel,
  input  logic                    cfg_edge,
  input  logic                    cfg_sat,
  input  logic                    cfg_en,
  input  logic [NUM_COUNTERS-1:0] clr_mask,
  input  logic [NUM_COUNTERS-1:0] ovf_clr_mask,
  input  logic                    snap,
  input  logic                    rd_req,
  input  logic [IDX_W-1:0]        rd_idx,
  input  logic                    rd_shadow,
  output logic                    rd_valid,
  output logic [CNT_WIDTH-1:0]    rd_data,
  output logic [NUM_COUNTERS-1:0] ovf_flags,
  input  logic [NUM_COUNTERS-1:0] ovf_irq_en,
  output logic                    irq
);
  logic [NUM_EVENTS-1:0] prev_q;
  logic [CNT_WIDTH-1:0] cnt [NUM_COUNTERS];
  logic [CNT_WIDTH-1:0] shadow [NUM_COUNTERS];
  logic rd_valid_q, irq_q, irq_d;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_slice
    perf_counter_slice #(
      .CNT_WIDTH (CNT_WIDTH),
      .NUM_EVENTS(NUM_EVENTS),
      .EVT_SEL_W (EVT_SEL_W)
    ) u_slice (
      .clk          (clk),
      .rst          (rst),
      .event_i      (event_in),
      .prev_i       (prev_q),
      .global_en_i  (global_en),
      .cfg_we_i     (cfg_we && (cfg_idx == IDX_W'(i))),
      .cfg_evt_sel_i(cfg_evt_sel),
      .cfg_edge_i   (cfg_edge),
      .cfg_sat_i    (cfg_sat),
      .cfg_en_i     (cfg_en),
      .clr_i        (clr_mask[i]),
      .ovf_clr_i    (ovf_clr_mask[i]),
      .snap_i       (snap),
      .count_o      (cnt[i]),
      .shadow_o     (shadow[i]),
      .ovf_o        (ovf_flags[i])
    );
  end
  always_comb begin
    rd_data_d = !rd_req ? rd_data_q : (32'(rd_idx) >= NUM_COUNTERS) ? '0 : rd_shadow ? shadow[rd_idx] : cnt[rd_idx];
    irq_d = |(ovf_flags & ovf_irq_en);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
      irq_q <= 1'b0;
    end else begin
      prev_q <= event_in;
      rd_valid_q <= rd_req;
      rd_data_q <= rd_data_d;
      irq_q <= irq_d;
    end
  end
  assign rd_valid = rd_valid_q;
  assign rd_data = rd_data_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed vectors against hand-computed counts for a 4-bit, 6-counter bank
module tb_perf_counter_bank;
  import perf_counter_pkg::*;
  localparam int CW = 4;
  localparam int NC = 6;
  localparam int NE = 16;
  localparam int SW = 4;
  localparam int IW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NE-1:0] event_in = '0;
  logic global_en = 1'b0;
  logic cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [SW-1:0] cfg_evt_sel = '0;
  logic cfg_edge = 1'b0;
  logic cfg_sat = 1'b0;
  logic cfg_en = 1'b0;
  logic [NC-1:0] clr_mask = '0;
  logic [NC-1:0] ovf_clr_mask = '0;
  logic snap = 1'b0;
  logic rd_req = 1'b0;
  logic [IW-1:0] rd_idx = '0;
  logic rd_shadow = 1'b0;
  logic rd_valid;
  logic [CW-1:0] rd_data;
  logic [NC-1:0] ovf_flags;
  logic [NC-1:0] ovf_irq_en = '0;
  logic irq;
  int total = 0;
  int passed = 0;
  perf_counter_bank #(.CNT_WIDTH(CW), .NUM_COUNTERS(NC), .NUM_EVENTS(NE)) dut (
    .clk(clk), .rst(rst), .event_in(event_in), .global_en(global_en),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_evt_sel(cfg_evt_sel), .cfg_edge(cfg_edge),
    .cfg_sat(cfg_sat), .cfg_en(cfg_en), .clr_mask(clr_mask), .ovf_clr_mask(ovf_clr_mask),
    .snap(snap), .rd_req(rd_req), .rd_idx(rd_idx), .rd_shadow(rd_shadow),
    .rd_valid(rd_valid), .rd_data(rd_data), .ovf_flags(ovf_flags),
    .ovf_irq_en(ovf_irq_en), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic cfg(input int idx, input int sel, input logic em, input logic sm, input logic en);
    cfg_we = 1'b1;
    cfg_idx = IW'(idx);
    cfg_evt_sel = SW'(sel);
    cfg_edge = em;
    cfg_sat = sm;
    cfg_en = en;
    tick();
    cfg_we = 1'b0;
  endtask
  task automatic rd(input string tag, input int idx, input logic sh, input int exp);
    rd_req = 1'b1;
    rd_idx = IW'(idx);
    rd_shadow = sh;
    tick();
    rd_req = 1'b0;
    check(tag, 32'(rd_data), exp);
    check({tag, "_valid"}, 32'(rd_valid), 1);
  endtask
  initial begin
    tick(2);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_ovf", 32'(ovf_flags), 0);
    check("rst_irq", 32'(irq), 0);
    rst = 1'b0;
    global_en = 1'b1;
    cfg(0, 3, MODE_EDGE, OVF_WRAP, 1'b1);
    cfg(1, 3, MODE_LEVEL, OVF_WRAP, 1'b1);
    event_in[3] = 1'b1;
    tick(5);
    event_in = '0;
    rd("edge_cnt0", 0, 1'b0, 1);
    rd("level_cnt1", 1, 1'b0, 5);
    tick();
    check("idle_rd_valid", 32'(rd_valid), 0);
    check("idle_rd_hold", 32'(rd_data), 5);
    cfg(2, 4, MODE_LEVEL, OVF_WRAP, 1'b1);
    cfg(3, 4, MODE_LEVEL, OVF_SAT, 1'b1);
    ovf_irq_en = 6'b000100;
    event_in[4] = 1'b1;
    tick(16);
    check("ovf_set", 32'(ovf_flags), 32'b001100);
    check("irq_not_yet", 32'(irq), 0);
    tick();
    check("irq_after_ovf", 32'(irq), 1);
    event_in = '0;
    rd("wrap_cnt2", 2, 1'b0, 1);
    rd("sat_cnt3", 3, 1'b0, 15);
    event_in[3] = 1'b1;
    tick(2);
    clr_mask = 6'b000010;
    tick();
    clr_mask = '0;
    event_in = '0;
    rd("clr_beats_inc", 1, 1'b0, 0);
    rd("edge_second_rise", 0, 1'b0, 2);
    event_in[4] = 1'b1;
    ovf_clr_mask = 6'b001100;
    tick();
    event_in = '0;
    ovf_clr_mask = '0;
    check("ovf_set_beats_clr", 32'(ovf_flags), 32'b001000);
    tick();
    check("irq_dropped", 32'(irq), 0);
    cfg(4, 6, MODE_LEVEL, OVF_WRAP, 1'b1);
    cfg(5, 7, MODE_LEVEL, OVF_WRAP, 1'b1);
    event_in[6] = 1'b1;
    event_in[7] = 1'b1;
    tick(10);
    event_in[6] = 1'b0;
    tick(2);
    event_in[6] = 1'b1;
    snap = 1'b1;
    rd_req = 1'b1;
    rd_idx = 3'd4;
    rd_shadow = 1'b0;
    tick();
    snap = 1'b0;
    rd_req = 1'b0;
    event_in = '0;
    check("rd_pre_update", 32'(rd_data), 10);
    rd("shadow4", 4, 1'b1, 10);
    rd("shadow5", 5, 1'b1, 12);
    rd("live4", 4, 1'b0, 11);
    rd("live5", 5, 1'b0, 13);
    event_in[3] = 1'b1;
    cfg(1, 5, MODE_LEVEL, OVF_WRAP, 1'b1);
    event_in[3] = 1'b0;
    event_in[5] = 1'b1;
    tick();
    event_in = '0;
    rd("cfg_timing", 1, 1'b0, 2);
    rd("rd_out_of_range", NC, 1'b0, 0);
    event_in[5] = 1'b1;
    tick();
    cfg(1, 5, MODE_EDGE, OVF_WRAP, 1'b1);
    tick();
    event_in = '0;
    rd("edge_switch_no_spurious", 1, 1'b0, 4);
    ovf_irq_en = 6'b001000;
    tick();
    check("irq_en_change", 32'(irq), 1);
    event_in[4] = 1'b1;
    rd_req = 1'b1;
    rd_idx = 3'd2;
    #2 rst = 1'b1;
    #1;
    check("async_rd_valid", 32'(rd_valid), 0);
    check("async_rd_data", 32'(rd_data), 0);
    check("async_ovf", 32'(ovf_flags), 0);
    check("async_irq", 32'(irq), 0);
    rd_req = 1'b0;
    tick();
    rst = 1'b0;
    tick(3);
    event_in = '0;
    rd("post_rst_no_count", 2, 1'b0, 0);
    rd("post_rst_shadow", 3, 1'b1, 0);
    check("post_rst_ovf", 32'(ovf_flags), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
